mac_n: RTL
==========

MAC_N -- requirements
Module: mac_n

Interface
REQ-001 SHALL provide parameter BW, default 8, element bit width (BW >= 2).
REQ-002 SHALL provide parameter N, default 4, vector length (N >= 1).
REQ-003 SHALL provide parameter SIGNED, default 0, where 0 means unsigned operands and 1 means two's-complement operands.
REQ-004 SHALL define derived localparam ACC_W = 2*BW + $clog2(N); the accumulator and result are ACC_W bits wide.
REQ-005 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous and active-low.
REQ-007 SHALL have port start  input  1  request to begin a dot product; sampled only in IDLE.
REQ-008 SHALL have port x_vec  input  N*BW  first operand vector; element i occupies bits [i*BW +: BW].
REQ-009 SHALL have port w_vec  input  N*BW  second operand vector, with the same packing as x_vec.
REQ-010 SHALL have port sum  output  ACC_W  registered result, sign-extended when SIGNED=1.
REQ-011 SHALL have port done  output  1  single-cycle pulse marking a new sum.
REQ-012 SHALL have port busy  output  1  high whenever state != IDLE.

Function
REQ-013 SHALL implement FSM states IDLE, RUN and DONE, plus an element index counter idx of width max(1, $clog2(N)).
REQ-014 IDLE with start=1 at edge k SHALL:
- capture x_vec and w_vec into internal operand registers;
- clear the accumulator and idx;
- move to RUN.
REQ-015 IDLE with start=0 SHALL hold all state.
REQ-016 RUN SHALL add x[idx]*w[idx] to the accumulator on each edge, using one multiply per cycle and captured operands only; input changes after edge k SHALL have no effect.
REQ-017 RUN SHALL increment idx on each edge; when idx == N-1 it SHALL instead:
- load sum with accumulator + final product;
- set done=1;
- move to DONE.
REQ-018 Latency: done SHALL be high in the cycle following edge k+N, i.e. exactly N+1 edges after start is sampled.
REQ-019 DONE SHALL return to IDLE on the next edge and clear done, so done is high for exactly one cycle.
REQ-020 start SHALL be ignored in RUN and DONE; the minimum start-to-start period is N+2 cycles.
REQ-021 Start held continuously high SHALL launch back-to-back operations every N+2 cycles.
REQ-022 sum SHALL hold its value from one completion until the next completion or reset.
REQ-023 When SIGNED=1, products and accumulation SHALL be two's-complement, with each product sign-extended to ACC_W bits.
REQ-024 When SIGNED=0, products and accumulation SHALL be zero-extended.
REQ-025 ACC_W SHALL be wide enough that no overflow is possible for any operands; no saturation logic exists.
REQ-026 N=1 SHALL work: RUN lasts one edge and done occurs 2 edges after start.

Reset
REQ-027 While rst=0, independent of clk, the block SHALL force:
- state=IDLE, idx=0, accumulator=0;
- operand registers=0;
- sum=0, done=0, busy=0.
REQ-028 Reset asserted mid-RUN or in DONE SHALL abort the operation with no done pulse, and sum SHALL read 0.
REQ-029 After rst deasserts, the first rising edge with start=1 SHALL be accepted normally.

Configuration
REQ-030 Macro MAC_N_RELU_EN, when defined, SHALL apply ReLU at the load of sum: a negative result (only possible with SIGNED=1) is stored as 0, otherwise the result is stored unchanged.
REQ-031 Without MAC_N_RELU_EN, sum SHALL be the raw accumulated result; interface and timing are identical in both builds.

Verification
REQ-032 BW=8, N=4, SIGNED=0: x=(1,2,3,4), w=(5,6,7,8), start pulse at edge k -> done high one cycle after edge k+4, sum=70, busy high from k through k+5.
REQ-033 BW=8, N=4, SIGNED=0: all x=w=255 -> sum=260100 (0x3F804), done for exactly one cycle.
REQ-034 BW=8, N=4, SIGNED=1: all x=w=-128 -> sum=65536. Then x=(-1,0,0,0), w=(5,0,0,0) -> sum=-5 (0x3FFFB) without MAC_N_RELU_EN, and sum=0 with it.
REQ-035 Change x_vec/w_vec one cycle after start is accepted -> result reflects the captured values only; start pulses during RUN/DONE are ignored.
REQ-036 Assert rst low two edges into RUN -> outputs are 0 immediately, without waiting for a clock edge, and no done pulse occurs. A subsequent start returns the correct result.
REQ-037 start held high for 20 cycles with N=4 -> done pulses exactly every 6 cycles, each with the correct sum.

Source files
------------

// File: rtl/mac_n.sv
// mac_n: sequential N-element dot product with one multiply per cycle.
// The optional MAC_N_RELU_EN macro clamps negative results to zero when sum is loaded.
module mac_n #(
  parameter int BW     = 8,
  parameter int N      = 4,
  parameter int SIGNED = 0,
  localparam int ACC_W = 2*BW + $clog2(N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [N*BW-1:0]   x_vec,
  input  logic [N*BW-1:0]   w_vec,
  output logic [ACC_W-1:0]  sum,
  output logic              done,
  output logic              busy
);

  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state;
  logic [IDX_W-1:0]  idx;
  logic [ACC_W-1:0]  acc;
  logic [N*BW-1:0]   x_reg;
  logic [N*BW-1:0]   w_reg;
  logic [BW-1:0]     x_el;
  logic [BW-1:0]     w_el;
  logic [ACC_W-1:0]  prod;
  logic [ACC_W-1:0]  acc_next;
  logic [ACC_W-1:0]  load_val;

  // Select the current element pair from the captured operands.
  always_comb begin
    x_el = '0;
    w_el = '0;
    for (int i = 0; i < N; i++) begin
      if (idx == IDX_W'(i)) begin
        x_el = x_reg[i*BW +: BW];
        w_el = w_reg[i*BW +: BW];
      end
    end
  end

  generate
    if (SIGNED != 0) begin : g_signed
      logic signed [2*BW-1:0] p;
      assign p    = $signed(x_el) * $signed(w_el);
      assign prod = ACC_W'(p);
    end else begin : g_unsigned
      logic [2*BW-1:0] p;
      assign p    = x_el * w_el;
      assign prod = ACC_W'(p);
    end
  endgenerate

  assign acc_next = acc + prod;

`ifdef MAC_N_RELU_EN
  // Only a signed build can produce a negative result; an unsigned MSB is magnitude.
  assign load_val = ((SIGNED != 0) && acc_next[ACC_W-1]) ? '0 : acc_next;
`else
  assign load_val = acc_next;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      idx   <= '0;
      acc   <= '0;
      x_reg <= '0;
      w_reg <= '0;
      sum   <= '0;
      done  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            x_reg <= x_vec;
            w_reg <= w_vec;
            acc   <= '0;
            idx   <= '0;
            state <= RUN;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          if (idx == IDX_W'(N-1)) begin
            sum   <= load_val;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            acc <= acc_next;
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
